// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length/payload/checksum frame
// over valid/ready, writes the payload sequentially and releases the CPU stall on a verified image.
module imem_loader #(
  parameter int DataWidth = 16,
  parameter int AddrBits  = 16,
  parameter int BaseAddr  = 0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 InValid,
  input  logic [DataWidth-1:0] InData,
  output logic                 InReady,
  output logic                 WriteEn,
  output logic [AddrBits-1:0]  WriteAddr,
  output logic [DataWidth-1:0] WriteData,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic                 CpuStall,
  output logic [AddrBits-1:0]  WordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Fit check needs one bit more than either operand so 2^AddrBits is representable.
  localparam int CW = ((DataWidth > AddrBits) ? DataWidth : AddrBits) + 1;
  localparam logic [CW-1:0]       FIT_MAX = (CW'(1) << AddrBits) - CW'(BaseAddr);
  localparam logic [AddrBits-1:0] BASE    = AddrBits'(BaseAddr);

  state_t               state, state_nxt;
  logic [DataWidth-1:0] remaining;
  logic [DataWidth-1:0] sum;
  logic [AddrBits-1:0]  ptr;
  logic                 xfer;
  logic                 start_ok;
  logic                 fits;

  assign xfer     = InValid && InReady;
  assign fits     = CW'(InData) <= FIT_MAX;
  assign start_ok = Start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  always_comb begin
    InReady  = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Error    = 1'b0;
    CpuStall = 1'b1;
    case (state)
      S_HEADER, S_LOAD, S_CHECK: begin
        InReady = 1'b1;
        Busy    = 1'b1;
      end
      S_DONE: begin
        Done     = 1'b1;
        CpuStall = 1'b0;
      end
      S_ERROR: Error = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (Start) state_nxt = S_HEADER;
      S_HEADER: begin
        if (xfer) begin
          if (InData == '0)  state_nxt = S_CHECK;
          else if (!fits)    state_nxt = S_ERROR;
          else               state_nxt = S_LOAD;
        end
      end
      S_LOAD:  if (xfer && (remaining == DataWidth'(1))) state_nxt = S_CHECK;
      S_CHECK: if (xfer) state_nxt = (InData == sum) ? S_DONE : S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and externally visible registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      WriteEn   <= 1'b0;
      WriteAddr <= BASE;
      WriteData <= '0;
      WordCount <= '0;
    end else begin
      state   <= state_nxt;
      WriteEn <= 1'b0;
      if (start_ok) WordCount <= '0;
      if ((state == S_LOAD) && xfer) begin
        WriteEn   <= 1'b1;
        WriteAddr <= ptr;
        WriteData <= InData;
        WordCount <= WordCount + AddrBits'(1);
      end
    end
  end

  // Datapath: pointer, countdown and running checksum
  always_ff @(posedge Clk) begin
    if (start_ok) sum <= '0;
    if ((state == S_HEADER) && xfer) begin
      remaining <= InData;
      ptr       <= BASE;
    end
    if ((state == S_LOAD) && xfer) begin
      sum       <= sum + InData;
      ptr       <= ptr + AddrBits'(1);
      remaining <= remaining - DataWidth'(1);
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the pipeline runs. It accepts a framed stream of 16-bit words (length header, payload, checksum) over a valid/ready handshake and drives the instruction memory's write port with sequential addresses. It holds the processor in stall until a complete, checksum-verified image is loaded. It sits between the host/boot interface and the write side of the IF-stage instruction memory; the fetch path only reads.

## Interface
- DataWidth, 16, instruction word width
- AddrBits, 16, instruction memory address width
- BaseAddr, 0, address of first loaded word
- Clk  in  1  clock, all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  begin a load; sampled only in IDLE, DONE, ERROR
- InValid  in  1  InData holds a word
- InData  in  DataWidth  stream word
- InReady  out  1  loader accepts InData this cycle; a transfer occurs when InValid && InReady
- WriteEn  out  1  instruction memory write strobe
- WriteAddr  out  AddrBits  instruction memory write address
- WriteData  out  DataWidth  instruction memory write data
- Busy  out  1  load in progress (HEADER, LOAD, CHECK)
- Done  out  1  last load verified
- Error  out  1  last load failed
- CpuStall  out  1  hold the pipeline
- WordCount  out  AddrBits  payload words written in the current/last load

## Operation
- Frame: header N (payload length), N payload words, one checksum word = sum of the payload words mod 2^DataWidth.
- States: IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
- IDLE: InReady=0. Start -> HEADER. Clears Done, Error, WordCount and the running sum.
- HEADER: InReady=1. On transfer, capture Remaining=N.
  - N=0 -> CHECK.
  - N > 2^AddrBits - BaseAddr -> ERROR (image does not fit; no writes).
  - Otherwise -> LOAD, with the address pointer at BaseAddr.
- LOAD: InReady=1. Each transfer:
  - register a write (WriteAddr=pointer, WriteData=InData);
  - Sum += InData; pointer++; WordCount++; Remaining--.
  - The transfer with Remaining==1 -> CHECK.
- CHECK: InReady=1. On transfer, InData==Sum -> DONE, else -> ERROR.
- DONE: Done=1, CpuStall=0. Start -> HEADER, which re-asserts CpuStall.
- ERROR: Error=1, CpuStall=1. Start -> HEADER.
- Start while Busy is ignored. Start in HEADER's entry cycle has no effect.
- No transfer occurs unless InValid=1. Gaps in InValid stall the FSM in place with no writes.
- Pointer arithmetic is AddrBits wide. The fit check guarantees the pointer never wraps during a write.
- Memory contents are never cleared by the loader. Reset mid-load leaves any already-written words in memory.

## Timing
- Reset (Reset_n=0 at a rising edge):
  - state=IDLE; CpuStall=1.
  - InReady, WriteEn, Busy, Done, Error = 0.
  - WriteAddr=BaseAddr, WriteData=0, WordCount=0.
  - Applies from any state, including mid-LOAD.
- InReady is decoded from registered state only, never from InValid.
- Write latency is 1 cycle: payload transfer at edge t gives WriteEn=1 for exactly the cycle after t, with WriteAddr/WriteData stable in that cycle.
- Back-to-back transfers give back-to-back write cycles (1 word/cycle).
- Done/Error rise one cycle after the checksum transfer. The final WriteEn can coincide with the checksum-accept cycle.
- Busy=1 from the cycle after Start is sampled until the cycle Done/Error rises.
- CpuStall falls in the same cycle Done rises and rises the cycle after a restart Start.
- WordCount updates in the same cycle as the corresponding WriteEn.

## Test plan
- Reset: hold Reset_n=0 two cycles mid-stream -> CpuStall=1, InReady=0, WriteEn=0, Busy=0, Done=0, Error=0, WordCount=0.
- Good load: Start; stream 3, 0x1111, 0x2222, 0x3333, 0x6666 with InValid continuously 1 -> writes (0,0x1111), (1,0x2222), (2,0x3333) on consecutive cycles; Done=1; CpuStall=0; WordCount=3.
- Bad checksum: same stream with checksum 0x6667 -> three writes occur; Error=1, Done=0, CpuStall=1.
- Throttled input: same good stream with InValid toggling 1,0,0,1,… -> exactly three WriteEn pulses, addresses 0..2; InReady stays 1; Done=1.
- Boundaries:
  - N=0 with checksum 0x0000 -> Done, no writes.
  - N=0xFFFF with BaseAddr=2 -> Error directly from HEADER, no writes.
  - Checksum wraparound: 0xFFFF, 0x0002 with checksum 0x0001 -> Done.
- Reset mid-LOAD after 2 of 3 words -> IDLE with WordCount=0; a new Start plus the full good stream -> Done, with writes restarting at address 0.
